// File: rtl/delay_timer_arbiter_pkg.sv
// Shared types, default sizes and the round-robin pick for delay_timer_arbiter.
package delay_timer_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FIN  = 2'd2
  } state_e;

  localparam int DEF_WIDTH = 4;
  localparam int DEF_NREQ  = 2;
  // Pick function works on a fixed-size vector so it can live in the package.
  localparam int MAXN      = 16;
  localparam int IDX_W     = 5;

  // First set bit of req[n-1:0] at or above ptr; if none, first set bit below ptr.
  // Caller guarantees at least one request is set.
  function automatic logic [IDX_W-1:0] rr_pick(
    input logic [MAXN-1:0]  req,
    input logic [IDX_W-1:0] ptr,
    input logic [IDX_W-1:0] n
  );
    logic [MAXN-1:0]  hi;
    logic [IDX_W-1:0] iv;
    logic [IDX_W-1:0] pick;
    logic             found;
    pick  = '0;
    found = 1'b0;
    for (int i = 0; i < MAXN; i++) begin
      iv    = IDX_W'(i);
      hi[i] = req[i] && (iv >= ptr) && (iv < n);
    end
    for (int i = 0; i < MAXN; i++) begin
      if (!found && hi[i]) begin
        pick  = IDX_W'(i);
        found = 1'b1;
      end
    end
    for (int i = 0; i < MAXN; i++) begin
      iv = IDX_W'(i);
      if (!found && req[i] && (iv < n)) begin
        pick  = iv;
        found = 1'b1;
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/delay_timer_arbiter_step_counter.sv
// Shared WIDTH-bit counter: register plus +1 carry-chain adder.
module step_counter
#(
  parameter int WIDTH = 4
)(
  input  logic             CLK,
  input  logic             RESETN,
  input  logic             CLR,
  input  logic             EN,
  output logic [WIDTH-1:0] O,
  output logic [WIDTH-1:0] SUM,
  output logic             COUT
);

  // Increment with the carry kept so the 2**WIDTH wrap is visible to the caller.
  assign {COUT, SUM} = {1'b0, O} + {{WIDTH{1'b0}}, 1'b1};

  // Count register: clear wins over enable.
  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN)  O <= '0;
    else if (CLR) O <= '0;
    else if (EN)  O <= SUM;
  end

endmodule

// File: rtl/delay_timer_arbiter.sv
// Round-robin arbiter that lends one step_counter to NREQ delay requesters.
module delay_timer_arbiter
  import delay_timer_arbiter_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int NREQ  = DEF_NREQ
)(
  input  logic                  CLK,
  input  logic                  RESETN,
  input  logic [NREQ-1:0]       REQ,
  input  logic [NREQ*WIDTH-1:0] LEN,
  output logic [NREQ-1:0]       GNT,
  output logic [NREQ-1:0]       DONE,
  output logic                  BUSY,
  output logic [WIDTH-1:0]      COUNT
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  state_e           r_state, w_nxt;
  logic [WIDTH-1:0] r_len;
  logic [IW-1:0]    r_win, r_ptr;
  logic [IDX_W-1:0] w_pick_full;
  logic [IW-1:0]    w_pick, w_ptr_nxt;
  logic [WIDTH-1:0] w_len_sel, w_sum;
  logic             w_cout, w_hit, w_abort;
  logic             w_load, w_en, w_adv;

  step_counter #(.WIDTH(WIDTH)) u_cnt (
    .CLK    (CLK),
    .RESETN (RESETN),
    .CLR    (w_load),
    .EN     (w_en),
    .O      (COUNT),
    .SUM    (w_sum),
    .COUT   (w_cout)
  );

  assign w_pick_full = rr_pick(MAXN'(REQ), IDX_W'(r_ptr), IDX_W'(NREQ));
  assign w_pick      = w_pick_full[IW-1:0];
  assign w_ptr_nxt   = (r_win == IW'(NREQ-1)) ? '0 : r_win + IW'(1);
  // len 0 only matches once the adder wraps, i.e. after 2**WIDTH cycles.
  assign w_hit       = (w_sum == r_len) && ((|r_len) || w_cout);
  assign w_abort     = !REQ[r_win];

  // Select the candidate winner's LEN slice.
  always_comb begin
    w_len_sel = '0;
    for (int i = 0; i < NREQ; i++)
      if (w_pick == IW'(i)) w_len_sel = LEN[i*WIDTH +: WIDTH];
  end

  // State register.
  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) r_state <= ST_IDLE;
    else         r_state <= w_nxt;
  end

  // Next state and counter/datapath controls; abort beats completion.
  always_comb begin
    w_nxt  = r_state;
    w_load = 1'b0;
    w_en   = 1'b0;
    w_adv  = 1'b0;
    case (r_state)
      ST_IDLE: if (|REQ) begin
        w_load = 1'b1;
        w_nxt  = ST_RUN;
      end
      ST_RUN: begin
        if (w_abort) begin
          w_nxt = ST_IDLE;
          w_adv = 1'b1;
        end else if (w_hit) begin
          w_nxt = ST_FIN;
        end else begin
          w_en = 1'b1;
        end
      end
      ST_FIN: begin
        w_nxt = ST_IDLE;
        w_adv = 1'b1;
      end
      default: w_nxt = ST_IDLE;
    endcase
  end

  // Job bookkeeping: latched length, winner, and round-robin pointer.
  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      r_len <= '0;
      r_win <= '0;
      r_ptr <= '0;
    end else begin
      if (w_load) begin
        r_len <= w_len_sel;
        r_win <= w_pick;
      end
      if (w_adv) r_ptr <= w_ptr_nxt;
    end
  end

  // Grant/done decode from state and winner; both zero in IDLE.
  always_comb begin
    GNT  = '0;
    DONE = '0;
    for (int i = 0; i < NREQ; i++) begin
      GNT[i]  = (r_state == ST_RUN) && (r_win == IW'(i));
      DONE[i] = (r_state == ST_FIN) && (r_win == IW'(i));
    end
  end

  assign BUSY = (r_state != ST_IDLE);

endmodule

// File: tb/tb_delay_timer_arbiter.sv
// Bench for delay_timer_arbiter: directed scenarios with literal checks,
// then randomized requesters, all checked each cycle against a job-level model.
module tb_delay_timer_arbiter;

  localparam int W  = 4;
  localparam int NR = 2;

  logic            CLK = 1'b0;
  logic            RESETN = 1'b0;
  logic [NR-1:0]   REQ = '0;
  logic [NR*W-1:0] LEN = '0;
  logic [NR-1:0]   GNT, DONE;
  logic            BUSY;
  logic [W-1:0]    COUNT;

  int n_cmp = 0;
  int n_err = 0;
  bit mon_en = 1'b0;

  delay_timer_arbiter #(.WIDTH(W), .NREQ(NR)) dut (
    .CLK(CLK), .RESETN(RESETN), .REQ(REQ), .LEN(LEN),
    .GNT(GNT), .DONE(DONE), .BUSY(BUSY), .COUNT(COUNT)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @%0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  // A job is: who owns the counter, how many run cycles remain, elapsed count.
  int m_run, m_fin, m_who, m_left, m_cnt, m_ptr;

  function automatic int pick_model(input logic [NR-1:0] r, input int p);
    for (int k = 0; k < NR; k++)
      if (r[(p + k) % NR]) return (p + k) % NR;
    return 0;
  endfunction

  function automatic int job_len(input logic [NR*W-1:0] l, input int who);
    int v;
    v = int'(l[who*W +: W]);
    return (v == 0) ? (1 << W) : v;
  endfunction

  always @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      m_run <= 0; m_fin <= 0; m_who <= 0; m_left <= 0; m_cnt <= 0; m_ptr <= 0;
    end else if (m_fin != 0) begin
      m_fin <= 0;
      m_ptr <= (m_who + 1) % NR;
    end else if (m_run != 0) begin
      if (!REQ[m_who]) begin
        m_run <= 0;
        m_ptr <= (m_who + 1) % NR;
      end else if (m_left == 1) begin
        m_run <= 0;
        m_fin <= 1;
      end else begin
        m_left <= m_left - 1;
        m_cnt  <= m_cnt + 1;
      end
    end else if (REQ != '0) begin
      m_who  <= pick_model(REQ, m_ptr);
      m_left <= job_len(LEN, pick_model(REQ, m_ptr));
      m_cnt  <= 0;
      m_run  <= 1;
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge CLK) begin
    if (mon_en) begin
      chk("gnt",   32'(GNT),   (m_run != 0) ? (32'd1 << m_who) : 32'd0);
      chk("done",  32'(DONE),  (m_fin != 0) ? (32'd1 << m_who) : 32'd0);
      chk("busy",  32'(BUSY),  32'((m_run != 0) || (m_fin != 0)));
      chk("count", 32'(COUNT), 32'(m_cnt));
    end
  end

  // ---------------- directed helpers ----------------
  task automatic nx();
    @(negedge CLK);
  endtask

  task automatic wait_done(input int idx);
    bit seen;
    seen = 1'b0;
    for (int c = 0; c < 40 && !seen; c++) begin
      nx();
      if (DONE[idx]) seen = 1'b1;
    end
    chk("done_timeout", 32'(seen), 32'd1);
  endtask

  task automatic do_reset();
    #1 RESETN = 1'b0; REQ = '0;
    nx(); nx();
    #1 RESETN = 1'b1;
  endtask

  initial begin
    logic [NR-1:0] d, g, r;
    mon_en = 1'b1;

    // 1: reset held, requests toggling -> everything quiet
    for (int i = 0; i < 4; i++) begin
      nx();
      #1 REQ = NR'(i);
      LEN = 8'h33;
      #1;
      chk("rst_gnt", 32'(GNT), 0); chk("rst_done", 32'(DONE), 0);
      chk("rst_busy", 32'(BUSY), 0); chk("rst_count", 32'(COUNT), 0);
    end
    #1 REQ = '0;
    nx();
    #1 RESETN = 1'b1;

    // 2: single job, LEN0=3
    LEN = {4'd0, 4'd3}; REQ = 2'b01;
    for (int i = 0; i < 3; i++) begin
      nx(); chk("t2_gnt", 32'(GNT), 1); chk("t2_cnt", 32'(COUNT), 32'(i));
    end
    nx(); chk("t2_done", 32'(DONE), 1); chk("t2_gnt_off", 32'(GNT), 0);
    #1 REQ = '0;
    nx(); chk("t2_busy", 32'(BUSY), 0); chk("t2_done_off", 32'(DONE), 0);

    // 3: wrap, LEN0=0 -> 16 cycles
    LEN = {4'd0, 4'd0}; REQ = 2'b01;
    for (int i = 0; i < 16; i++) begin
      nx(); chk("t3_gnt", 32'(GNT), 1); chk("t3_cnt", 32'(COUNT), 32'(i));
    end
    nx(); chk("t3_done", 32'(DONE), 1);
    #1 REQ = '0;

    // 4: contention from pointer 0
    do_reset();
    LEN = {4'd5, 4'd2}; REQ = 2'b11;
    nx(); chk("t4_gnt0", 32'(GNT), 1); chk("t4_cnt0", 32'(COUNT), 0);
    nx(); chk("t4_cnt1", 32'(COUNT), 1);
    nx(); chk("t4_done0", 32'(DONE), 1);
    #1 REQ = 2'b10;
    nx(); chk("t4_idle", 32'(BUSY), 0);
    nx(); chk("t4_gnt1", 32'(GNT), 2); chk("t4_cnt1_0", 32'(COUNT), 0);
    for (int i = 1; i < 5; i++) begin
      nx(); chk("t4_cnt_r1", 32'(COUNT), 32'(i));
    end
    nx(); chk("t4_done1", 32'(DONE), 2);
    #1 REQ = 2'b11;
    nx(); chk("t4_idle2", 32'(BUSY), 0);
    nx(); chk("t4_regnt0", 32'(GNT), 1);
    nx(); nx(); chk("t4_redone0", 32'(DONE), 1);

    // 5: abort of req1 at COUNT=2, pending req0 granted after one IDLE cycle
    #1 REQ = 2'b11; LEN = {4'd7, 4'd4};
    nx(); chk("t5_idle", 32'(BUSY), 0);
    nx(); chk("t5_gnt1", 32'(GNT), 2);
    nx(); nx(); chk("t5_cnt2", 32'(COUNT), 2);
    #1 REQ = 2'b01;
    nx(); chk("t5_abort_gnt", 32'(GNT), 0); chk("t5_abort_done", 32'(DONE), 0);
    chk("t5_abort_busy", 32'(BUSY), 0);
    nx(); chk("t5_gnt0", 32'(GNT), 1); chk("t5_cnt0", 32'(COUNT), 0);
    wait_done(0);
    #1 REQ = '0;

    // 6: async reset mid-RUN at COUNT=4
    nx();
    #1 REQ = 2'b01; LEN = {4'd0, 4'd9};
    for (int i = 0; i < 5; i++) begin
      nx(); chk("t6_cnt", 32'(COUNT), 32'(i));
    end
    #1 RESETN = 1'b0;
    #1;
    chk("t6_gnt", 32'(GNT), 0); chk("t6_busy", 32'(BUSY), 0);
    chk("t6_count", 32'(COUNT), 0); chk("t6_done", 32'(DONE), 0);
    nx();
    #1 RESETN = 1'b1;
    nx(); chk("t6_regnt", 32'(GNT), 1); chk("t6_recnt", 32'(COUNT), 0);
    wait_done(0);
    #1 REQ = '0;

    // Random requesters: hold until DONE, occasional abort, LEN churn, rare reset.
    for (int cyc = 0; cyc < 3000; cyc++) begin
      nx();
      d = DONE; g = GNT;
      #1;
      r = REQ;
      for (int i = 0; i < NR; i++) begin
        if (r[i] && d[i]) r[i] = 1'b0;
        else if (r[i] && g[i] && ($urandom_range(0, 49) == 0)) r[i] = 1'b0;
        else if (!r[i] && ($urandom_range(0, 3) == 0)) begin
          r[i] = 1'b1;
          LEN[i*W +: W] = W'($urandom_range(0, 15));
        end else if ($urandom_range(0, 7) == 0) begin
          LEN[i*W +: W] = W'($urandom_range(0, 15));
        end
      end
      REQ = r;
      if ($urandom_range(0, 999) == 0) begin
        RESETN = 1'b0;
        #2 RESETN = 1'b1;
      end
    end

    nx();
    mon_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
